// File: rtl/instruction_fetch_reg_if.sv
// Instruction-memory read channel between the fetch unit (master) and memory (slave).
interface instruction_fetch_reg_if #(
    parameter int WORD_LENGTH = 32
);
    logic [WORD_LENGTH-1:0] mem_addr;
    logic                   mem_rd;
    logic                   mem_ready;
    logic [WORD_LENGTH-1:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_rd,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_rd,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/instruction_fetch_reg.sv
// Multicycle instruction fetch and instruction register with MIPS field decode.
// Optional fetch timeout (counter, ERR state, fetch_err) is built with `define FETCH_TIMEOUT_EN.
module instruction_fetch_reg #(
    parameter int WORD_LENGTH    = 32,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       fetch_start,
    input  logic [WORD_LENGTH-1:0]     pc,
    instruction_fetch_reg_if.master    mem,
    output logic                       busy,
    output logic                       instr_valid,
    output logic [WORD_LENGTH-1:0]     instr,
    output logic [5:0]                 opcode,
    output logic [4:0]                 rs,
    output logic [4:0]                 rt,
    output logic [4:0]                 rd,
    output logic [4:0]                 shamt,
    output logic [5:0]                 funct,
    output logic [WORD_LENGTH/2-1:0]   imm,
    output logic                       fetch_err
);

`ifdef FETCH_TIMEOUT_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ERR   = 2'd2
    } state_t;

    localparam int unsigned           CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]      CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             fetch_err_r;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1
    } state_t;
`endif

    state_t                 state_r;
    state_t                 next_state_s;
    logic [WORD_LENGTH-1:0] mem_addr_r;
    logic [WORD_LENGTH-1:0] mem_addr_s;
    logic [WORD_LENGTH-1:0] ir_r;
    logic [WORD_LENGTH-1:0] ir_s;
    logic                   instr_valid_r;
    logic                   instr_valid_s;
    logic                   mem_rd_r;
    logic                   busy_r;

    // Next-state and next-register-value decode for the fetch FSM.
    always_comb begin
        next_state_s  = state_r;
        mem_addr_s    = mem_addr_r;
        ir_s          = ir_r;
        instr_valid_s = instr_valid_r;
`ifdef FETCH_TIMEOUT_EN
        cnt_s         = cnt_r;
`endif
        case (state_r)
            IDLE: begin
                if (fetch_start) begin
                    mem_addr_s    = pc;
                    instr_valid_s = 1'b0;
`ifdef FETCH_TIMEOUT_EN
                    cnt_s         = {CNT_W{1'b0}};
`endif
                    next_state_s  = FETCH;
                end else begin
                    next_state_s  = IDLE;
                end
            end
            FETCH: begin
                // A late mem_ready still beats the timeout in the same cycle.
                if (mem.mem_ready) begin
                    ir_s          = mem.mem_rdata;
                    instr_valid_s = 1'b1;
                    next_state_s  = IDLE;
`ifdef FETCH_TIMEOUT_EN
                end else if (cnt_r >= CNT_LAST) begin
                    next_state_s  = ERR;
                end else begin
                    cnt_s         = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);
                    next_state_s  = FETCH;
                end
`else
                end else begin
                    next_state_s  = FETCH;
                end
`endif
            end
`ifdef FETCH_TIMEOUT_EN
            ERR: begin
                if (fetch_start) begin
                    mem_addr_s    = pc;
                    instr_valid_s = 1'b0;
                    cnt_s         = {CNT_W{1'b0}};
                    next_state_s  = FETCH;
                end else begin
                    next_state_s  = ERR;
                end
            end
`endif
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State, IR and registered handshake outputs; async reset drops mem_rd at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= IDLE;
            mem_addr_r    <= {WORD_LENGTH{1'b0}};
            ir_r          <= {WORD_LENGTH{1'b0}};
            instr_valid_r <= 1'b0;
            mem_rd_r      <= 1'b0;
            busy_r        <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            cnt_r         <= {CNT_W{1'b0}};
            fetch_err_r   <= 1'b0;
`endif
        end else begin
            state_r       <= next_state_s;
            mem_addr_r    <= mem_addr_s;
            ir_r          <= ir_s;
            instr_valid_r <= instr_valid_s;
            mem_rd_r      <= (next_state_s == FETCH);
            busy_r        <= (next_state_s == FETCH);
`ifdef FETCH_TIMEOUT_EN
            cnt_r         <= cnt_s;
            fetch_err_r   <= (next_state_s == ERR);
`endif
        end
    end

    assign mem.mem_addr = mem_addr_r;
    assign mem.mem_rd   = mem_rd_r;
    assign busy         = busy_r;
    assign instr_valid  = instr_valid_r;
    assign instr        = ir_r;

    // Field decode follows IR regardless of instr_valid.
    assign opcode = ir_r[31:26];
    assign rs     = ir_r[25:21];
    assign rt     = ir_r[20:16];
    assign rd     = ir_r[15:11];
    assign shamt  = ir_r[10:6];
    assign funct  = ir_r[5:0];
    assign imm    = ir_r[WORD_LENGTH/2-1:0];

`ifdef FETCH_TIMEOUT_EN
    assign fetch_err = fetch_err_r;
`else
    assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_reg.sv
// Directed bench for instruction_fetch_reg: table of fetches plus reset, ignored-input and timeout sequences.
module tb_instruction_fetch_reg;
    localparam int WL = 32;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          fetch_start;
    logic [WL-1:0] pc;
    logic          busy;
    logic          instr_valid;
    logic [WL-1:0] instr;
    logic [5:0]    opcode;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
    logic [4:0]    shamt;
    logic [5:0]    funct;
    logic [15:0]   imm;
    logic          fetch_err;

    int n_vec = 0;
    int n_err = 0;
    logic [WL-1:0] exp_ir;

    instruction_fetch_reg_if #(.WORD_LENGTH(WL)) mem_if ();

    instruction_fetch_reg #(.WORD_LENGTH(WL), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_start (fetch_start),
        .pc          (pc),
        .mem         (mem_if),
        .busy        (busy),
        .instr_valid (instr_valid),
        .instr       (instr),
        .opcode      (opcode),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .shamt       (shamt),
        .funct       (funct),
        .imm         (imm),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rdata;
        int          waits;
        int          poke_at;
        logic [5:0]  opc;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [5:0]  fn;
        logic [15:0] imm;
    } vec_t;

    vec_t tbl [5];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    initial begin
        tbl[0] = '{32'h0040_0000, 32'h2008_FFFC, 0, -1, 6'h08, 5'd0,  5'd8,  5'd31, 5'd31, 6'h3C, 16'hFFFC};
        tbl[1] = '{32'h0040_0004, 32'h0128_5020, 3,  1, 6'h00, 5'd9,  5'd8,  5'd10, 5'd0,  6'h20, 16'h5020};
        tbl[2] = '{32'h0040_0008, 32'h8D09_0004, 1, -1, 6'h23, 5'd8,  5'd9,  5'd0,  5'd0,  6'h04, 16'h0004};
        tbl[3] = '{32'hBFC0_0000, 32'hFFFF_FFFF, 6,  6, 6'h3F, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF};
        tbl[4] = '{32'h0040_000C, 32'h3C01_1001, 2, -1, 6'h0F, 5'd0,  5'd1,  5'd2,  5'd0,  6'h01, 16'h1001};

        reset = 1'b0;
        fetch_start = 1'b0;
        pc = 32'h0;
        mem_if.mem_ready = 1'b0;
        mem_if.mem_rdata = 32'h0;
        exp_ir = 32'h0;
        #1;
        chk("rst_mem_rd", {31'h0, mem_if.mem_rd}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_addr", mem_if.mem_addr, 32'h0);
        chk("rst_err", {31'h0, fetch_err}, 32'h0);
        tick;
        tick;
        reset = 1'b1;
        tick;

        for (int v = 0; v < 5; v++) begin
            pc = tbl[v].pc;
            mem_if.mem_rdata = tbl[v].rdata;
            fetch_start = 1'b1;
            tick;
            fetch_start = 1'b0;
            for (int i = 0; i <= tbl[v].waits; i++) begin
                chk("wait_busy", {31'h0, busy}, 32'h1);
                chk("wait_mem_rd", {31'h0, mem_if.mem_rd}, 32'h1);
                chk("wait_valid", {31'h0, instr_valid}, 32'h0);
                chk("wait_ir_hold", instr, exp_ir);
                chk("wait_addr", mem_if.mem_addr, tbl[v].pc);
                if (i == tbl[v].poke_at) begin
                    fetch_start = 1'b1;
                    pc = ~tbl[v].pc;
                end
                if (i == tbl[v].waits) mem_if.mem_ready = 1'b1;
                tick;
                fetch_start = 1'b0;
                mem_if.mem_ready = 1'b0;
            end
            exp_ir = tbl[v].rdata;
            chk("done_valid", {31'h0, instr_valid}, 32'h1);
            chk("done_busy", {31'h0, busy}, 32'h0);
            chk("done_mem_rd", {31'h0, mem_if.mem_rd}, 32'h0);
            chk("instr", instr, tbl[v].rdata);
            chk("opcode", {26'h0, opcode}, {26'h0, tbl[v].opc});
            chk("rs", {27'h0, rs}, {27'h0, tbl[v].rs});
            chk("rt", {27'h0, rt}, {27'h0, tbl[v].rt});
            chk("rd", {27'h0, rd}, {27'h0, tbl[v].rd});
            chk("shamt", {27'h0, shamt}, {27'h0, tbl[v].sh});
            chk("funct", {26'h0, funct}, {26'h0, tbl[v].fn});
            chk("imm", {16'h0, imm}, {16'h0, tbl[v].imm});
            tick;
            chk("single_completion", {31'h0, busy}, 32'h0);
            chk("valid_hold", {31'h0, instr_valid}, 32'h1);
        end

        // mem_ready in IDLE must not touch IR
        mem_if.mem_rdata = 32'hDEAD_BEEF;
        mem_if.mem_ready = 1'b1;
        tick;
        tick;
        mem_if.mem_ready = 1'b0;
        chk("idle_ready_ir", instr, exp_ir);
        chk("idle_ready_valid", {31'h0, instr_valid}, 32'h1);
        chk("idle_ready_busy", {31'h0, busy}, 32'h0);

        // Long wait: 14 empty FETCH cycles, then the 15th decides
        pc = 32'h0040_0100;
        mem_if.mem_rdata = 32'h1234_5678;
        fetch_start = 1'b1;
        tick;
        fetch_start = 1'b0;
        for (int i = 1; i < TO; i++) begin
            chk("long_busy", {31'h0, busy}, 32'h1);
            chk("long_err", {31'h0, fetch_err}, 32'h0);
            tick;
        end
        chk("long_busy15", {31'h0, busy}, 32'h1);
        tick;
`ifdef FETCH_TIMEOUT_EN
        chk("to_err", {31'h0, fetch_err}, 32'h1);
        chk("to_mem_rd", {31'h0, mem_if.mem_rd}, 32'h0);
        chk("to_busy", {31'h0, busy}, 32'h0);
        chk("to_valid", {31'h0, instr_valid}, 32'h0);
        mem_if.mem_ready = 1'b1;
        tick;
        mem_if.mem_ready = 1'b0;
        chk("err_ignores_ready", {31'h0, fetch_err}, 32'h1);
        chk("err_ir_hold", instr, exp_ir);
        pc = 32'h0040_0200;
        fetch_start = 1'b1;
        tick;
        fetch_start = 1'b0;
        chk("err_clear", {31'h0, fetch_err}, 32'h0);
        chk("err_refetch_busy", {31'h0, busy}, 32'h1);
        chk("err_refetch_addr", mem_if.mem_addr, 32'h0040_0200);
        mem_if.mem_rdata = 32'h2402_0005;
        mem_if.mem_ready = 1'b1;
        tick;
        mem_if.mem_ready = 1'b0;
        exp_ir = 32'h2402_0005;
        chk("err_refetch_instr", instr, exp_ir);
        chk("err_refetch_valid", {31'h0, instr_valid}, 32'h1);

        // Boundary: mem_ready in the 15th FETCH cycle completes normally
        pc = 32'h0040_0300;
        mem_if.mem_rdata = 32'hAC22_0008;
        fetch_start = 1'b1;
        tick;
        fetch_start = 1'b0;
        for (int i = 1; i < TO; i++) tick;
        chk("bnd_busy15", {31'h0, busy}, 32'h1);
        mem_if.mem_ready = 1'b1;
        tick;
        mem_if.mem_ready = 1'b0;
        exp_ir = 32'hAC22_0008;
        chk("bnd_valid", {31'h0, instr_valid}, 32'h1);
        chk("bnd_err", {31'h0, fetch_err}, 32'h0);
        chk("bnd_instr", instr, exp_ir);
`else
        for (int i = 0; i < 5; i++) begin
            chk("nto_busy", {31'h0, busy}, 32'h1);
            chk("nto_err", {31'h0, fetch_err}, 32'h0);
            tick;
        end
        mem_if.mem_ready = 1'b1;
        tick;
        mem_if.mem_ready = 1'b0;
        exp_ir = 32'h1234_5678;
        chk("nto_valid", {31'h0, instr_valid}, 32'h1);
        chk("nto_instr", instr, exp_ir);
`endif

        // Asynchronous reset in the middle of a fetch
        pc = 32'h0040_0400;
        mem_if.mem_rdata = 32'h0800_0000;
        fetch_start = 1'b1;
        tick;
        fetch_start = 1'b0;
        chk("pre_rst_mem_rd", {31'h0, mem_if.mem_rd}, 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_mem_rd", {31'h0, mem_if.mem_rd}, 32'h0);
        chk("arst_busy", {31'h0, busy}, 32'h0);
        chk("arst_valid", {31'h0, instr_valid}, 32'h0);
        chk("arst_instr", instr, 32'h0);
        chk("arst_addr", mem_if.mem_addr, 32'h0);
        mem_if.mem_ready = 1'b1;
        tick;
        reset = 1'b1;
        tick;
        mem_if.mem_ready = 1'b0;
        chk("arst_no_completion", {31'h0, instr_valid}, 32'h0);
        chk("arst_ir_zero", instr, 32'h0);
        chk("arst_idle", {31'h0, busy}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_reg.md
# instruction_fetch_reg

Multicycle instruction fetch and instruction register (IR) for the MIPS datapath. It issues a read to instruction memory at the current PC and waits for the memory handshake. It latches the returned word and splits it into decoded fields. Its `imm` output feeds the `Data` input of the sign-extension stage directly, and `opcode`/`funct` feed the control unit.

## Interface
- `WORD_LENGTH`, 32, datapath width; field slicing assumes 32.
- `TIMEOUT_CYCLES`, 15, maximum cycles waiting for `mem_ready`; used only with the timeout feature.

- `clk` input 1 — system clock, rising edge.
- `reset` input 1 — asynchronous, active-low reset.
- `fetch_start` input 1 — single-cycle request from control to fetch at `pc`.
- `pc` input WORD_LENGTH — fetch address, sampled when `fetch_start` is accepted.
- `mem_addr` output WORD_LENGTH — registered read address.
- `mem_rd` output 1 — read request, high for the whole FETCH state.
- `mem_ready` input 1 — memory returns valid `mem_rdata` this cycle.
- `mem_rdata` input WORD_LENGTH — instruction word.
- `busy` output 1 — high in FETCH.
- `instr_valid` output 1 — IR holds a freshly fetched instruction.
- `instr` output WORD_LENGTH — full IR contents.
- `opcode` [31:26], `rs` [25:21], `rt` [20:16], `rd` [15:11], `shamt` [10:6], `funct` [5:0] — outputs, combinational slices of IR.
- `imm` output WORD_LENGTH/2 — IR[15:0], goes to the sign extender.
- `fetch_err` output 1 — timeout flag; held 0 when the feature is compiled out.

## Operation
- FSM states: IDLE, FETCH, ERR. ERR exists only with the timeout feature.
- **IDLE**
  - `fetch_start`=1: `mem_addr`<=`pc`, `instr_valid`<=0, counter<=0, go to FETCH.
  - Otherwise stay in IDLE.
- **FETCH**
  - `mem_rd`=1, `busy`=1.
  - `mem_ready`=1: IR<=`mem_rdata`, `instr_valid`<=1, go to IDLE.
  - Otherwise the counter increments.
- **ERR** (timeout feature only)
  - `mem_rd`=0, `fetch_err`=1.
  - `fetch_start`=1: clear `fetch_err` and start a new fetch, same as in IDLE.
- IR keeps its previous value during FETCH; only `instr_valid` drops.
- Field outputs always reflect IR, valid or not.
- `fetch_start` is ignored while in FETCH; there is no queueing.
- `mem_ready` is ignored in IDLE and ERR.
- If `mem_ready` and `fetch_start` are both high in FETCH, the fetch completes and `fetch_start` is dropped.
- Counter width is $clog2(TIMEOUT_CYCLES+1). It saturates and cannot wrap.
- Reset values: state IDLE, IR 0, `mem_addr` 0, `mem_rd` 0, `busy` 0, `instr_valid` 0, `fetch_err` 0, counter 0.
- Reset asserted mid-fetch drops `mem_rd` immediately (asynchronous), with no completion.

## Timing
- `mem_rd`, `busy`, and `mem_addr` are registered state decodes. All are valid the cycle after `fetch_start` is sampled.
- Minimum latency: `fetch_start` at edge N, `mem_ready` high in the cycle after N → IR and `instr_valid` update at edge N+2.
- Latency is 1 + (cycles `mem_ready` is low) + 1.
- `instr_valid` stays high until the next accepted `fetch_start`.
- Timeout: after TIMEOUT_CYCLES consecutive FETCH cycles with `mem_ready`=0, the state moves to ERR at the next edge.
- A `mem_ready` arriving in the cycle the timeout is reached wins: the fetch completes normally.

## Configuration
- Macro: `FETCH_TIMEOUT_EN`.
- Defined: counter, ERR state, and `fetch_err` behave as described above.
- Undefined: no counter, no ERR state. FETCH waits indefinitely for `mem_ready`. `fetch_err` is tied to 0 and the port remains present.

## Test plan
- Reset: assert `reset`=0 mid-FETCH → `mem_rd`, `busy`, `instr_valid`, `instr` all 0 without waiting for an edge.
- Zero-wait fetch: `pc`=0x0040_0000, `fetch_start` pulse, `mem_ready`=1 with `mem_rdata`=0x2008_FFFC
  - `mem_addr`=0x0040_0000 one cycle later.
  - `instr_valid`=1 two edges after the pulse.
  - `opcode`=0x08, `rs`=0, `rt`=8, `imm`=0xFFFC.
- Wait states: `mem_ready` held low for 3 cycles, `mem_rdata`=0x0128_5020
  - `instr_valid` at edge N+5.
  - `funct`=0x20, `rd`=10.
  - IR keeps its old value and `instr_valid`=0 while waiting.
- Ignored inputs: `fetch_start` during FETCH with a different `pc` → `mem_addr` unchanged, one completion only. `mem_ready` pulsed in IDLE → IR unchanged.
- Timeout (`FETCH_TIMEOUT_EN`, TIMEOUT_CYCLES=15), `mem_ready` never asserted
  - ERR after 15 FETCH cycles, with `fetch_err`=1 and `mem_rd`=0.
  - A subsequent `fetch_start` clears `fetch_err`.
- Timeout boundary: `mem_ready`=1 in the 15th FETCH cycle → normal completion, `fetch_err` stays 0.
